// File: rtl/dcache_l1_resp_if.sv
// rtl/dcache_l1_resp_if.sv - external memory bus bundle for the L1 data-cache responder
interface dcache_l1_resp_if;
  logic [31:0] busAddr;
  logic [63:0] busData;
  logic [7:0]  busMask;
  logic [1:0]  busOpm;
  logic [63:0] busDataIn;
  logic [1:0]  busOK;

  modport master (
    output busAddr, busData, busMask, busOpm,
    input  busDataIn, busOK
  );

  modport slave (
    input  busAddr, busData, busMask, busOpm,
    output busDataIn, busOK
  );
endinterface

// File: rtl/dcache_l1_resp.sv
// rtl/dcache_l1_resp.sv - direct-mapped write-through L1 data-cache responder (EX1 capture, EX2 answer)
module dcache_l1_resp #(
  parameter int NLINES = 64,
  parameter int TAGW   = 23
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [31:0]       regInAddr,
  input  logic [7:0]        regInOpm,
  input  logic [63:0]       regInData,
  input  logic              pipeHold,
  input  logic              regInFlush,
  output logic [63:0]       memDataOut,
  output logic [1:0]        memDataOK,
  dcache_l1_resp_if.master  bus
);
  localparam int IDXW = $clog2(NLINES);
  localparam logic [1:0] ST_READY = 2'b00;
  localparam logic [1:0] ST_OK    = 2'b01;
  localparam logic [1:0] ST_HOLD  = 2'b10;
  localparam logic [1:0] ST_FAULT = 2'b11;

  typedef enum logic [2:0] {S_IDLE, S_RD, S_WR, S_REL, S_DONE, S_FLT} state_t;

  state_t            state_q, state_d;
  logic [31:0]       rq_addr_q, rq_addr_d;
  logic [4:0]        rq_opm_q, rq_opm_d;
  logic [63:0]       rq_data_q, rq_data_d;
  logic [63:0]       res_q, res_d;
  logic              flush_pend_q, flush_pend_d;
  logic [31:0]       bus_addr_q, bus_addr_d;
  logic [63:0]       bus_data_q, bus_data_d;
  logic [7:0]        bus_mask_q, bus_mask_d;
  logic [1:0]        bus_opm_q, bus_opm_d;
  logic [NLINES-1:0] valid_q, valid_d;
  logic [TAGW-1:0]   tag_q  [NLINES];
  logic [63:0]       line_q [NLINES];

  logic              line_we, tag_we;
  logic [63:0]       line_wdata, merged, st_data, dout;
  logic [7:0]        st_mask;
  logic [1:0]        status;
  logic              capture, flushing, misaligned, hit, is_load, is_store;
  logic [IDXW-1:0]   idx;
  logic [TAGW-1:0]   rq_tag;
  logic [2:0]        ofs;
  logic [1:0]        sz;
  logic              unused_opm;

  // rq_opm_q keeps only {type[1:0], zero-extend, size[1:0]}
  assign unused_opm = ^regInOpm[5:3];
  assign idx        = rq_addr_q[3 +: IDXW];
  assign rq_tag     = rq_addr_q[3+IDXW +: TAGW];
  assign ofs        = rq_addr_q[2:0];
  assign sz         = rq_opm_q[1:0];
  assign is_load    = (rq_opm_q[4:3] == 2'b01);
  assign is_store   = (rq_opm_q[4:3] == 2'b10);
  assign hit        = valid_q[idx] && (tag_q[idx] == rq_tag);
  assign flushing   = flush_pend_q | regInFlush;

  function automatic logic [63:0] extract(input logic [63:0] q, input logic [2:0] a,
                                          input logic [1:0] s, input logic zx);
    logic [63:0] sh;
    sh = q >> {a, 3'b000};
    case (s)
      2'd0:    extract = {{56{~zx & sh[7]}},  sh[7:0]};
      2'd1:    extract = {{48{~zx & sh[15]}}, sh[15:0]};
      2'd2:    extract = {{32{~zx & sh[31]}}, sh[31:0]};
      default: extract = q;
    endcase
  endfunction

  always_comb begin
    misaligned = 1'b0;
    st_data    = rq_data_q;
    st_mask    = 8'hFF;
    case (sz)
      2'd0: begin misaligned = 1'b0;       st_data = {8{rq_data_q[7:0]}};  st_mask = 8'h01 << ofs; end
      2'd1: begin misaligned = ofs[0];     st_data = {4{rq_data_q[15:0]}}; st_mask = 8'h03 << ofs; end
      2'd2: begin misaligned = |ofs[1:0];  st_data = {2{rq_data_q[31:0]}}; st_mask = 8'h0F << ofs; end
      default: begin misaligned = |ofs;    st_data = rq_data_q;            st_mask = 8'hFF;        end
    endcase
  end

  always_comb begin
    merged = line_q[idx];
    for (int i = 0; i < 8; i++) begin
      if (bus_mask_q[i]) merged[8*i +: 8] = bus_data_q[8*i +: 8];
    end
  end

  always_comb begin
    state_d      = state_q;
    rq_addr_d    = rq_addr_q;
    rq_opm_d     = rq_opm_q;
    rq_data_d    = rq_data_q;
    res_d        = res_q;
    flush_pend_d = flush_pend_q;
    bus_addr_d   = bus_addr_q;
    bus_data_d   = bus_data_q;
    bus_mask_d   = bus_mask_q;
    bus_opm_d    = bus_opm_q;
    valid_d      = valid_q;
    line_we      = 1'b0;
    tag_we       = 1'b0;
    line_wdata   = merged;
    status       = ST_READY;
    dout         = '0;
    capture      = !pipeHold && (state_q == S_IDLE || state_q == S_DONE);

    case (state_q)
      S_IDLE: begin
        if (is_load || is_store) begin
          if (misaligned) begin
            status = ST_FAULT;
          end else if (is_load && hit) begin
            status = ST_OK;
            dout   = extract(line_q[idx], ofs, sz, rq_opm_q[2]);
          end else begin
            status     = ST_HOLD;
            state_d    = is_load ? S_RD : S_WR;
            bus_opm_d  = is_load ? 2'b01 : 2'b10;
            bus_addr_d = {rq_addr_q[31:3], 3'b000};
            bus_data_d = is_load ? 64'd0 : st_data;
            bus_mask_d = is_load ? 8'h00 : st_mask;
          end
        end
      end
      S_RD, S_WR: begin
        status       = ST_HOLD;
        flush_pend_d = flushing;
        if (bus.busOK == ST_OK) begin
          bus_opm_d = 2'b00;
          state_d   = S_REL;
          if (!flushing && state_q == S_RD) begin
            valid_d[idx] = 1'b1;
            tag_we       = 1'b1;
            line_we      = 1'b1;
            line_wdata   = bus.busDataIn;
            res_d        = extract(bus.busDataIn, ofs, sz, rq_opm_q[2]);
          end else if (!flushing) begin
            line_we = hit;
            res_d   = '0;
          end
        end else if (bus.busOK == ST_FAULT) begin
          bus_opm_d    = 2'b00;
          state_d      = flushing ? S_IDLE : S_FLT;
          flush_pend_d = 1'b0;
          if (flushing) rq_opm_d = '0;
        end
      end
      S_REL: begin
        status       = ST_HOLD;
        flush_pend_d = flushing;
        if (bus.busOK == ST_READY) begin
          state_d      = flushing ? S_IDLE : S_DONE;
          flush_pend_d = 1'b0;
          if (flushing) rq_opm_d = '0;
        end
      end
      S_DONE: begin
        status = ST_OK;
        dout   = res_q;
      end
      S_FLT: begin
        status = ST_FAULT;
      end
      default: state_d = S_IDLE;
    endcase

    // A flush in a quiescent state cancels any bus op the IDLE decode just scheduled
    if (regInFlush && (state_q == S_IDLE || state_q == S_DONE || state_q == S_FLT)) begin
      rq_opm_d  = '0;
      state_d   = S_IDLE;
      bus_opm_d = bus_opm_q;
    end

    if (capture) begin
      rq_addr_d = regInAddr;
      rq_opm_d  = regInFlush ? 5'd0 : {regInOpm[7:6], regInOpm[2:0]};
      rq_data_d = regInData;
      state_d   = S_IDLE;
      bus_opm_d = 2'b00;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q      <= S_IDLE;
      rq_addr_q    <= '0;
      rq_opm_q     <= '0;
      rq_data_q    <= '0;
      res_q        <= '0;
      flush_pend_q <= 1'b0;
      bus_addr_q   <= '0;
      bus_data_q   <= '0;
      bus_mask_q   <= '0;
      bus_opm_q    <= 2'b00;
      valid_q      <= '0;
    end else begin
      state_q      <= state_d;
      rq_addr_q    <= rq_addr_d;
      rq_opm_q     <= rq_opm_d;
      rq_data_q    <= rq_data_d;
      res_q        <= res_d;
      flush_pend_q <= flush_pend_d;
      bus_addr_q   <= bus_addr_d;
      bus_data_q   <= bus_data_d;
      bus_mask_q   <= bus_mask_d;
      bus_opm_q    <= bus_opm_d;
      valid_q      <= valid_d;
    end
  end

  always_ff @(posedge clock) begin
    if (tag_we)  tag_q[idx]  <= rq_tag;
    if (line_we) line_q[idx] <= line_wdata;
  end

  assign memDataOK   = status;
  assign memDataOut  = dout;
  assign bus.busAddr = bus_addr_q;
  assign bus.busData = bus_data_q;
  assign bus.busMask = bus_mask_q;
  assign bus.busOpm  = bus_opm_q;
endmodule

// File: tb/tb_dcache_l1_resp.sv
// tb/tb_dcache_l1_resp.sv - directed self-checking bench for dcache_l1_resp
module tb_dcache_l1_resp;
  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] regInAddr = '0;
  logic [7:0]  regInOpm = '0;
  logic [63:0] regInData = '0;
  logic        pipeHold = 1'b1;
  logic        regInFlush = 1'b0;
  logic [63:0] memDataOut;
  logic [1:0]  memDataOK;

  dcache_l1_resp_if bus_if();

  dcache_l1_resp dut (
    .clock(clock), .reset(reset), .regInAddr(regInAddr), .regInOpm(regInOpm),
    .regInData(regInData), .pipeHold(pipeHold), .regInFlush(regInFlush),
    .memDataOut(memDataOut), .memDataOK(memDataOK), .bus(bus_if)
  );

  always #5 clock = ~clock;

  int n_tests = 0;
  int n_fail  = 0;

  localparam logic [7:0] LD_B  = 8'h40;
  localparam logic [7:0] LD_BU = 8'h44;
  localparam logic [7:0] LD_W  = 8'h41;
  localparam logic [7:0] LD_L  = 8'h42;
  localparam logic [7:0] LD_Q  = 8'h43;
  localparam logic [7:0] ST_W  = 8'h81;

  logic [1:0]  b_opm;
  logic [31:0] b_addr;
  logic [7:0]  b_mask;
  logic [63:0] b_wdata;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic issue(input logic [31:0] a, input logic [7:0] op, input logic [63:0] d);
    regInAddr = a; regInOpm = op; regInData = d; pipeHold = 1'b0;
    tick();
    pipeHold = 1'b1; regInOpm = 8'h00;
  endtask

  task automatic run_bus(input int nhold, input logic [63:0] rdata, input logic [1:0] st,
                         output logic [1:0] opm, output logic [31:0] addr,
                         output logic [7:0] mask, output logic [63:0] wdata);
    int k;
    k = 0;
    while (bus_if.busOpm == 2'b00 && k < 10) begin tick(); k++; end
    n_tests++;
    if (bus_if.busOpm == 2'b00) begin
      n_fail++; $display("FAIL bus_start: busOpm=00 after %0d cycles, required nonzero", k);
    end
    opm = bus_if.busOpm; addr = bus_if.busAddr; mask = bus_if.busMask; wdata = bus_if.busData;
    bus_if.busOK = 2'b10;
    repeat (nhold) tick();
    bus_if.busOK = st; bus_if.busDataIn = rdata;
    tick();
    bus_if.busOK = 2'b00;
    tick();
  endtask

  task automatic test_reset();
    #12;
    n_tests++; if (memDataOK !== 2'b00) begin n_fail++; $display("FAIL rst_ok: got %b required 00", memDataOK); end
    n_tests++; if (memDataOut !== 64'd0) begin n_fail++; $display("FAIL rst_data: got %h required 0", memDataOut); end
    n_tests++; if (bus_if.busOpm !== 2'b00) begin n_fail++; $display("FAIL rst_opm: got %b required 00", bus_if.busOpm); end
    n_tests++; if (bus_if.busAddr !== 32'd0 || bus_if.busMask !== 8'd0 || bus_if.busData !== 64'd0) begin
      n_fail++; $display("FAIL rst_bus: addr %h mask %h data %h required all 0", bus_if.busAddr, bus_if.busMask, bus_if.busData);
    end
    tick(); reset = 1'b1; tick();
    n_tests++; if (memDataOK !== 2'b00) begin n_fail++; $display("FAIL post_rst_ok: got %b required 00", memDataOK); end
  endtask

  task automatic test_cold_miss();
    issue(32'h100, LD_Q, 64'd0);
    n_tests++; if (memDataOK !== 2'b10) begin n_fail++; $display("FAIL miss_hold: got %b required 10", memDataOK); end
    n_tests++; if (bus_if.busOpm !== 2'b00) begin n_fail++; $display("FAIL miss_opm_n1: got %b required 00", bus_if.busOpm); end
    run_bus(3, 64'h1122334455667788, 2'b01, b_opm, b_addr, b_mask, b_wdata);
    n_tests++; if (b_opm !== 2'b01) begin n_fail++; $display("FAIL miss_opm: got %b required 01", b_opm); end
    n_tests++; if (b_addr !== 32'h100) begin n_fail++; $display("FAIL miss_addr: got %h required 100", b_addr); end
    n_tests++; if (memDataOK !== 2'b01) begin n_fail++; $display("FAIL miss_done_ok: got %b required 01", memDataOK); end
    n_tests++; if (memDataOut !== 64'h1122334455667788) begin n_fail++; $display("FAIL miss_data: got %h required 1122334455667788", memDataOut); end
  endtask

  task automatic test_extension();
    logic [31:0] a_tab [3] = '{32'h100, 32'h100, 32'h106};
    logic [7:0]  o_tab [3] = '{LD_B, LD_BU, LD_W};
    logic [63:0] e_tab [3] = '{64'hFFFFFFFFFFFFFF88, 64'h88, 64'h1122};
    for (int i = 0; i < 3; i++) begin
      issue(a_tab[i], o_tab[i], 64'd0);
      n_tests++; if (memDataOK !== 2'b01) begin n_fail++; $display("FAIL ext_ok[%0d]: got %b required 01", i, memDataOK); end
      n_tests++; if (memDataOut !== e_tab[i]) begin n_fail++; $display("FAIL ext_data[%0d]: got %h required %h", i, memDataOut, e_tab[i]); end
      tick();
      n_tests++; if (bus_if.busOpm !== 2'b00) begin n_fail++; $display("FAIL ext_opm[%0d]: got %b required 00", i, bus_if.busOpm); end
    end
  endtask

  task automatic test_store();
    issue(32'h102, ST_W, 64'hBEEF);
    n_tests++; if (memDataOK !== 2'b10) begin n_fail++; $display("FAIL st_hold: got %b required 10", memDataOK); end
    run_bus(1, 64'd0, 2'b01, b_opm, b_addr, b_mask, b_wdata);
    n_tests++; if (b_opm !== 2'b10) begin n_fail++; $display("FAIL st_opm: got %b required 10", b_opm); end
    n_tests++; if (b_addr !== 32'h100) begin n_fail++; $display("FAIL st_addr: got %h required 100", b_addr); end
    n_tests++; if (b_mask !== 8'h0C) begin n_fail++; $display("FAIL st_mask: got %h required 0c", b_mask); end
    n_tests++; if (b_wdata[31:16] !== 16'hBEEF) begin n_fail++; $display("FAIL st_lane: got %h required beef", b_wdata[31:16]); end
    n_tests++; if (memDataOK !== 2'b01) begin n_fail++; $display("FAIL st_done: got %b required 01", memDataOK); end
    issue(32'h100, LD_Q, 64'd0);
    n_tests++; if (memDataOK !== 2'b01) begin n_fail++; $display("FAIL st_rd_ok: got %b required 01", memDataOK); end
    n_tests++; if (memDataOut !== 64'h11223344BEEF7788) begin n_fail++; $display("FAIL st_merge: got %h required 11223344beef7788", memDataOut); end
  endtask

  task automatic test_misaligned();
    issue(32'h102, LD_L, 64'd0);
    n_tests++; if (memDataOK !== 2'b11) begin n_fail++; $display("FAIL mis_fault: got %b required 11", memDataOK); end
    tick(); tick();
    n_tests++; if (bus_if.busOpm !== 2'b00 || memDataOK !== 2'b11) begin
      n_fail++; $display("FAIL mis_hold: opm %b status %b required 00/11", bus_if.busOpm, memDataOK);
    end
    regInFlush = 1'b1; tick(); regInFlush = 1'b0;
    n_tests++; if (memDataOK !== 2'b00) begin n_fail++; $display("FAIL mis_flush: got %b required 00", memDataOK); end
  endtask

  task automatic test_bus_fault();
    issue(32'h200, LD_Q, 64'd0);
    run_bus(0, 64'd0, 2'b11, b_opm, b_addr, b_mask, b_wdata);
    n_tests++; if (memDataOK !== 2'b11) begin n_fail++; $display("FAIL bf_fault: got %b required 11", memDataOK); end
    tick(); tick();
    n_tests++; if (memDataOK !== 2'b11 || bus_if.busOpm !== 2'b00) begin
      n_fail++; $display("FAIL bf_stay: status %b opm %b required 11/00", memDataOK, bus_if.busOpm);
    end
    regInFlush = 1'b1; tick(); regInFlush = 1'b0;
    n_tests++; if (memDataOK !== 2'b00) begin n_fail++; $display("FAIL bf_flush: got %b required 00", memDataOK); end
    issue(32'h200, LD_Q, 64'd0);
    n_tests++; if (memDataOK !== 2'b10) begin n_fail++; $display("FAIL bf_remiss: got %b required 10", memDataOK); end
    run_bus(0, 64'hA5A5A5A55A5A5A5A, 2'b01, b_opm, b_addr, b_mask, b_wdata);
    n_tests++; if (memDataOut !== 64'hA5A5A5A55A5A5A5A) begin n_fail++; $display("FAIL bf_data: got %h required a5a5a5a55a5a5a5a", memDataOut); end
  endtask

  task automatic test_alias();
    issue(32'h300, LD_Q, 64'd0);
    n_tests++; if (memDataOK !== 2'b10) begin n_fail++; $display("FAIL al_miss: got %b required 10", memDataOK); end
    run_bus(1, 64'hCAFEF00D12345678, 2'b01, b_opm, b_addr, b_mask, b_wdata);
    n_tests++; if (b_addr !== 32'h300) begin n_fail++; $display("FAIL al_addr: got %h required 300", b_addr); end
    n_tests++; if (memDataOut !== 64'hCAFEF00D12345678) begin n_fail++; $display("FAIL al_data: got %h required cafef00d12345678", memDataOut); end
    issue(32'h100, LD_Q, 64'd0);
    n_tests++; if (memDataOK !== 2'b10) begin n_fail++; $display("FAIL al_evict: got %b required 10", memDataOK); end
    run_bus(0, 64'h0102030405060708, 2'b01, b_opm, b_addr, b_mask, b_wdata);
    issue(32'h100, LD_BU, 64'd0);
    n_tests++; if (memDataOK !== 2'b01 || memDataOut !== 64'h08) begin
      n_fail++; $display("FAIL al_refill_hit: status %b data %h required 01/08", memDataOK, memDataOut);
    end
  endtask

  task automatic test_reset_mid();
    int k;
    issue(32'h400, LD_Q, 64'd0);
    k = 0;
    while (bus_if.busOpm == 2'b00 && k < 10) begin tick(); k++; end
    n_tests++; if (bus_if.busOpm !== 2'b01) begin n_fail++; $display("FAIL rm_rd: got %b required 01", bus_if.busOpm); end
    reset = 1'b0; #1;
    n_tests++; if (bus_if.busOpm !== 2'b00 || memDataOK !== 2'b00) begin
      n_fail++; $display("FAIL rm_drop: opm %b status %b required 00/00", bus_if.busOpm, memDataOK);
    end
    tick(); reset = 1'b1; tick();
    issue(32'h100, LD_Q, 64'd0);
    n_tests++; if (memDataOK !== 2'b10) begin n_fail++; $display("FAIL rm_cold: got %b required 10", memDataOK); end
    run_bus(0, 64'h5555AAAA5555AAAA, 2'b01, b_opm, b_addr, b_mask, b_wdata);
    n_tests++; if (memDataOK !== 2'b01 || memDataOut !== 64'h5555AAAA5555AAAA) begin
      n_fail++; $display("FAIL rm_fill: status %b data %h required 01/5555aaaa5555aaaa", memDataOK, memDataOut);
    end
  endtask

  initial begin
    bus_if.busOK = 2'b00;
    bus_if.busDataIn = 64'd0;
    test_reset();
    test_cold_miss();
    test_extension();
    test_store();
    test_misaligned();
    test_bus_fault();
    test_alias();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/dcache_l1_resp.md
# dcache_l1_resp

Direct-mapped, write-through L1 data-cache responder for the EX1/EX2 memory path. It captures the memory request issued in EX1 and answers it during EX2 with load data and a 2-bit status: READY, OK, HOLD or FAULT. Misses and all stores go through a simple external bus handshake. While a request is unresolved the block holds HOLD, which EX2 turns into a pipeline stall.

## Interface
Parameters:
- `NLINES`, default 64: number of cache lines (one 64-bit qword each); the index is addr[8:3].
- `TAGW`, default 23: tag width, addr[31:9].

Ports:
- `clock`  in  1  single core clock.
- `reset`  in  1  asynchronous, active-low.
- `regInAddr`  in  32  EX1 effective address.
- `regInOpm`  in  8  op mode:
  - [7:6]: 00 none, 01 load, 10 store, 11 reserved (treated as none).
  - [1:0]: size; 0=B, 1=W, 2=L, 3=Q.
  - [2]: zero-extend load.
- `regInData`  in  64  store data, right-aligned.
- `pipeHold`  in  1  global pipeline hold; no request is captured while it is high.
- `regInFlush`  in  1  drops the captured request and clears a FAULT.
- `memDataOut`  out  64  load result, extended to 64 bits.
- `memDataOK`  out  2  status: 00 READY, 01 OK, 10 HOLD, 11 FAULT.
- `busAddr`  out  32  qword-aligned bus address.
- `busData`  out  64  write data, placed in byte lanes.
- `busMask`  out  8  write byte-enables.
- `busOpm`  out  2  bus command: 00 idle, 01 read, 10 write.
- `busDataIn`  in  64  read data.
- `busOK`  in  2  bus status, same encoding as `memDataOK`.

## Operation
- **Capture.** At each rising edge with `pipeHold`=0 and FSM in IDLE or DONE, latch addr, opm and data into the request registers (rq*) and enter IDLE. Otherwise rq* hold their values.
- **Array.** valid[NLINES], tag[NLINES] and data[NLINES] × 64, read combinationally at rq index. Hit = valid & tag match.
- **Alignment.** Misaligned means addr[0] set for W, addr[1:0]≠0 for L, addr[2:0]≠0 for Q. A misaligned request produces FAULT, issues no bus op and does not touch the array.
- **Load extract.** Little-endian lane select by addr[2:0]. Sign-extend from the top bit of the size unless opm[2]=1; Q passes through unchanged.
- **Store lanes.** Data is replicated into lanes by size. Mask values:
  - B: 1<<a[2:0]
  - W: 3<<a[2:0]
  - L: 0x0F<<a[2:0]
  - Q: 0xFF
- **FSM states:**
  - IDLE: evaluate rq.
    - opm none → READY.
    - Misaligned → FAULT.
    - Load hit → OK plus data.
    - Load miss → HOLD, next state RD.
    - Store → HOLD, next state WR.
  - RD: `busOpm`=01, `busAddr`={addr[31:3],000}.
    - `busOK`=OK → fill the line (valid=1, tag, data), next state REL, result = extract(`busDataIn`).
    - `busOK`=FAULT → next state FLT.
  - WR: `busOpm`=10 with data and mask.
    - `busOK`=OK → if hit, merge masked bytes into the line; next state REL.
    - `busOK`=FAULT → next state FLT.
  - REL: `busOpm`=00. Wait for `busOK`=READY, then go to DONE. `memDataOK` stays HOLD.
  - DONE: `memDataOK`=OK, `memDataOut`=registered result. Leave on capture.
  - FLT: `busOpm`=00, `memDataOK`=FAULT. Stay until `regInFlush`, then go to IDLE with rq opm set to none.
- **Flush.**
  - In IDLE, DONE or FLT, `regInFlush` clears rq opm to none at the edge.
  - In RD, WR or REL, the bus handshake completes, the fill or merge is discarded, and the FSM goes to IDLE with opm none.
- **Bus protocol.** Address, data and mask stay stable while `busOpm`≠00. `busOK`=HOLD keeps the FSM waiting in place.

## Timing
- **Reset values (asynchronous).** All valid bits 0, FSM in IDLE, rq opm none. Outputs: `memDataOK`=00, `memDataOut`=0, `busOpm`=00, `busAddr`=0, `busData`=0, `busMask`=0.
- **Reset mid-transaction.** The bus command drops immediately. Fills in progress are lost.
- **Load hit.** Issued in EX1 cycle N; `memDataOK`=OK with data in cycle N+1.
- **Miss or store.**
  - HOLD is driven from cycle N+1.
  - `busOpm` is asserted from cycle N+2, because it is registered from FSM state.
  - With `busOK`=OK in cycle M, the fill happens at the end of M.
  - REL takes at least one cycle; DONE (OK) is reached in cycle M+2 at the earliest.
- **Same-index back-to-back loads.** A load that follows a fill to the same index is a hit in its EX2 cycle, because the array is written before the next capture.
- **Hold contract.** `memDataOK` combinational status [1]=1 implies the core holds `pipeHold`=1. The block also refuses capture outside IDLE/DONE as a safeguard.
- **Status stability.** `memDataOK` is glitch-free per cycle and derived from registered state plus the array read.

## Test plan
1. **Cold load miss.** Reset, then load Q at 0x100. Expect `memDataOK`=10 and `busOpm`=01, `busAddr`=0x100. Bus returns 0x1122334455667788 with OK after 3 HOLD cycles, then READY. Expect OK with `memDataOut`=0x1122334455667788.
2. **Extension on hit.**
   - Load B signed at 0x100 → 0xFFFFFFFFFFFFFF88.
   - Load B unsigned at 0x100 → 0x88.
   - Load W signed at 0x106 → 0x1122.
   - Each is a 1-cycle OK with `busOpm` remaining 00.
3. **Store W 0xBEEF at 0x102.** Expect `busOpm`=10, `busAddr`=0x100, `busMask`=0x0C, `busData`[31:16]=0xBEEF. After completion, load Q at 0x100 hits → 0x11223344BEEF7788.
4. **Misaligned load.** Load L at 0x102 → `memDataOK`=11 next cycle, `busOpm` never leaves 00. Pulse `regInFlush` → READY.
5. **Bus fault.** Load miss at 0x200 with bus returning FAULT → `memDataOK` stays 11 until `regInFlush`. A subsequent load at 0x200 misses again.
6. **Aliasing and reset.**
   - Load 0x300, which has the same index as 0x100 → miss, evicts 0x100. Reloading 0x100 → miss.
   - Assert `reset` low during RD → `busOpm`=00 at once. Loading 0x100 after reset → miss.
